// File: rtl/bus_sequencer.sv
// bus_sequencer: phase sequencer and bus controller for the 8-bit CPU datapath.
//
// Each instruction steps through fetch -> decode -> execute -> writeback, one
// cycle per phase. At the execute edge the register-file save bus is loaded
// according to the opcode. An I/O move (opcode 10 with the I/O register index
// as destination or source) detours through a wait state. The instruction
// stalls there until the port handshake completes.
//
// Handshake semantics: a transfer completes on the rising clock edge where
// valid and ready are both high and enable is high. The producer holds valid
// and its data stable until that edge. While enable is low, the handshake
// outputs keep their values, but no transfer completes.
//
// Optional build macro: BUS_SEQ_TIMEOUT_EN. When it is defined, each I/O wait
// is bounded by TIMEOUT cycles. An expired wait is aborted, and the sticky
// io_timeout flag is raised. When it is undefined, waits are unbounded and
// io_timeout is tied low.

module bus_sequencer #(
  parameter int         DATA_W  = 8,
  parameter logic [2:0] IO_ADDR = 3'b110,
  parameter int         TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        opcode,
  input  logic [5:0]        arg,
  input  logic [2:0]        arg0,
  input  logic [2:0]        arg1,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] loadbus,
  input  logic              cond_result,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fetch,
  output logic              decode,
  output logic              execute,
  output logic              writeback,
  output logic [DATA_W-1:0] savebus,
  output logic              regs_save,
  output logic              pc_set,
  output logic              io_timeout,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_WAIT_IN   = 3'd4;
  localparam logic [2:0] S_WAIT_OUT  = 3'd5;

  localparam logic [1:0] OP_CONST = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_COND  = 2'b11;

  logic [2:0] state;

  // The destination index is checked first. A move with both indices at the
  // I/O port is therefore an output.
  logic is_io_out;
  logic is_io_in;

  assign is_io_out = (arg0 == IO_ADDR);
  assign is_io_in  = (arg0 != IO_ADDR) && (arg1 == IO_ADDR);

`ifdef BUS_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       timeout_q;
  logic       wait_expired;

  // The wait expires in the wait cycle that would bring the count to TIMEOUT.
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign io_timeout   = timeout_q;
`else
  assign io_timeout   = 1'b0;
`endif

  // Phase FSM together with the registered save bus and the I/O port state.
  // The whole block freezes while enable is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      savebus   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
`ifdef BUS_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else if (enable) begin
      case (state)
        S_FETCH: begin
          state <= S_DECODE;
        end

        S_DECODE: begin
          state <= S_EXECUTE;
        end

        S_EXECUTE: begin
`ifdef BUS_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          case (opcode)
            OP_CONST: begin
              savebus <= {{(DATA_W-6){1'b0}}, arg};
              state   <= S_WRITEBACK;
            end
            OP_ALU: begin
              savebus <= alu_result;
              state   <= S_WRITEBACK;
            end
            OP_MOVE: begin
              if (is_io_out) begin
                out_data  <= loadbus;
                out_valid <= 1'b1;
                savebus   <= '0;
                state     <= S_WAIT_OUT;
              end else if (is_io_in) begin
                // savebus keeps its old value until the input arrives.
                in_ready <= 1'b1;
                state    <= S_WAIT_IN;
              end else begin
                savebus <= loadbus;
                state   <= S_WRITEBACK;
              end
            end
            default: begin
              savebus <= '0;
              state   <= S_WRITEBACK;
            end
          endcase
        end

        S_WAIT_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_WRITEBACK;
          end
`ifdef BUS_SEQ_TIMEOUT_EN
          else if (wait_expired) begin
            out_valid <= 1'b0;
            savebus   <= '0;
            timeout_q <= 1'b1;
            state     <= S_WRITEBACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        S_WAIT_IN: begin
          if (in_valid && in_ready) begin
            savebus  <= in_data;
            in_ready <= 1'b0;
            state    <= S_WRITEBACK;
          end
`ifdef BUS_SEQ_TIMEOUT_EN
          else if (wait_expired) begin
            // An aborted input still writes back, with a zero value.
            in_ready  <= 1'b0;
            savebus   <= '0;
            timeout_q <= 1'b1;
            state     <= S_WRITEBACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        S_WRITEBACK: begin
          state <= S_FETCH;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // Phase strobes and writeback enables are decoded from the state register
  // and gated by enable.
  always_comb begin
    fetch     = enable && (state == S_FETCH);
    decode    = enable && (state == S_DECODE);
    execute   = enable && (state == S_EXECUTE);
    writeback = enable && (state == S_WRITEBACK);
    regs_save = enable && (state == S_WRITEBACK) &&
                (opcode != OP_COND) && (arg0 != IO_ADDR);
    pc_set    = enable && (state == S_WRITEBACK) &&
                (opcode == OP_COND) && cond_result;
  end

  assign state_dbg = state;

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Single-clock phase sequencer and bus controller for the 8-bit CPU datapath.
- Generates the fetch/decode/execute/writeback phase strobes and drives the register-file save bus, save enable and PC load enable.
- Runs the ready/valid handshakes for the CPU input and output ports, stalling the instruction until each transfer completes.
- Sits between the Controller outputs and the RegisterFile, Counter, ALU and ConditionalUnit; it replaces the level-sensitive bus-control logic with a synchronous FSM.

Parameters:
DATA_W, 8, datapath width.
IO_ADDR, 3'b110, register index reserved for the I/O port.
TIMEOUT, 16, maximum number of wait cycles per I/O transfer (used only with BUS_SEQ_TIMEOUT_EN).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous reset, active-high.
enable  in  1  run enable; low freezes the FSM.
opcode  in  2  decoded opcode from the Controller.
arg  in  6  constant field.
arg0  in  3  destination register index.
arg1  in  3  source register index.
alu_result  in  DATA_W  ALU output.
loadbus  in  DATA_W  RegisterFile load bus.
cond_result  in  1  ConditionalUnit result.
in_data  in  DATA_W  CPU input data.
in_valid  in  1  input data valid.
in_ready  out  1  sequencer accepts input.
out_data  out  DATA_W  CPU output data.
out_valid  out  1  output data valid.
out_ready  in  1  consumer accepts output.
fetch, decode, execute, writeback  out  1 each  phase strobes.
savebus  out  DATA_W  RegisterFile save bus.
regs_save  out  1  RegisterFile write enable.
pc_set  out  1  PC load enable.
io_timeout  out  1  sticky timeout flag.

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- States: S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_WAIT_IN, S_WAIT_OUT.
- Reset (next clock edge, at any time, including mid-wait):
  - state = S_FETCH.
  - savebus, out_data = 0.
  - out_valid, in_ready, io_timeout = 0.
  - A pending transfer is discarded.
- Phase strobes are decoded from the state register and ANDed with enable:
  - fetch = S_FETCH, decode = S_DECODE, execute = S_EXECUTE, writeback = S_WRITEBACK.
  - All strobes are 0 in the wait states.
- enable low:
  - The state and all registers hold; strobes, regs_save and pc_set are 0.
  - in_ready and out_valid hold their values, but no handshake completes while enable is low.
- Normal sequence is S_FETCH → S_DECODE → S_EXECUTE → S_WRITEBACK → S_FETCH, giving 4 cycles per instruction.
- opcode, arg, arg0 and arg1 are stable from S_EXECUTE through S_WRITEBACK (Controller guarantee).
- At the S_EXECUTE edge, the save bus is registered per opcode:
  - 00: savebus = {2'b00, arg}.
  - 01: savebus = alu_result.
  - 10 with arg0 == IO_ADDR: out_data = loadbus, out_valid = 1, savebus = 0, go to S_WAIT_OUT. arg0 is checked first, so arg0 == arg1 == IO_ADDR is an output.
  - 10 with arg1 == IO_ADDR: in_ready = 1, go to S_WAIT_IN.
  - 10 otherwise: savebus = loadbus.
  - 11: savebus = 0.
- S_WAIT_OUT:
  - out_data stays stable and out_valid stays high until out_valid && out_ready is sampled.
  - On that edge: out_valid = 0, go to S_WRITEBACK.
  - Minimum of 1 wait cycle.
- S_WAIT_IN:
  - in_ready stays high until in_valid && in_ready is sampled.
  - On that edge: savebus = in_data, in_ready = 0, go to S_WRITEBACK.
- S_WRITEBACK (combinational, gated by enable):
  - regs_save = (opcode != 11) && (arg0 != IO_ADDR).
  - pc_set = (opcode == 11) && cond_result. cond_result is sampled only in this state.
- savebus holds its value until the next S_EXECUTE or S_WAIT_IN completion.
- I/O instruction latency is 4 + the number of wait cycles (at least 5).

Optional Feature:
- Macro: BUS_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to either wait state and increments each enabled wait cycle.
  - On reaching TIMEOUT without a handshake: out_valid and in_ready are dropped, savebus = 0, io_timeout is set, and the FSM goes to S_WRITEBACK.
  - For an aborted input, regs_save is still asserted with savebus = 0.
  - io_timeout is sticky until reset.
- Undefined: the wait is unbounded, and io_timeout is tied to 0.

Test Plan:
1. Reset, then enable = 1, opcode = 00, arg = 6'h2A, arg0 = 1 → fetch, decode, execute, writeback each high in cycles 1–4; savebus = 8'h2A in cycle 4; regs_save = 1 in cycle 4 only; pc_set = 0.
2. opcode = 11 with cond_result = 1 → pc_set = 1 and regs_save = 0 in writeback. Repeat with cond_result = 0 → pc_set = 0.
3. opcode = 10, arg0 = 6, loadbus = 8'h5C, out_ready low for 3 cycles then high → out_valid high for 4 cycles with out_data = 8'h5C stable; instruction takes 8 cycles; regs_save = 0.
4. opcode = 10, arg0 = 2, arg1 = 6, in_valid raised 2 cycles after in_ready with in_data = 8'h81 → savebus = 8'h81; regs_save = 1 in the following writeback cycle; in_ready = 0 afterwards.
5. enable dropped for 3 cycles in S_EXECUTE → no strobes, state held; the execute strobe resumes on re-enable and the instruction completes normally. Reset asserted during S_WAIT_OUT → out_valid = 0 and fetch = 1 in the next cycle.
6. With BUS_SEQ_TIMEOUT_EN, TIMEOUT = 16, out_ready held at 0 → after 16 wait cycles out_valid = 0, io_timeout = 1 (sticky), and writeback occurs. Without the macro → out_valid stays high indefinitely.
